keycode_action_repeater: RTL

Converts raw USB HID keycode bytes from the MicroBlaze keycode GPIO into per-action, frame-synchronous game events. Each action gets an initial-press pulse and an optional delayed auto-repeat (DAS/ARR). It sits between `mb_block`'s keycode outputs and the game-logic block. It replaces the single `keycode0_gpio[7:0]` connection with any number of keycode slots and any number of mapped actions.

---
 rtl/keycode_action_repeater.sv | 126 ++++++++++++
 1 files changed

// File: rtl/keycode_action_repeater.sv
// Maps HID keycode bytes to per-action frame-synchronous press/auto-repeat pulses.
// Pulse 2 cycles after frame_sync rise, 1 cycle wide; held 1 cycle after keycode; no backpressure.
module keycode_action_repeater #(
   parameter int                         NUM_SLOTS    = 4,
   parameter int                         NUM_ACTIONS  = 6,
   parameter logic [8*NUM_ACTIONS-1:0]   ACTION_CODES = 48'h14_2C_1A_16_07_04,
   parameter logic [NUM_ACTIONS-1:0]     REPEAT_MASK  = 6'b000111,
   parameter int                         DAS_FRAMES   = 10,
   parameter int                         ARR_FRAMES   = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     frame_sync,
   input  logic                     enable,
   input  logic [8*NUM_SLOTS-1:0]   keycode,
   output logic [NUM_ACTIONS-1:0]   action_pulse,
   output logic [NUM_ACTIONS-1:0]   action_held
);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LATCH} state_t;

   localparam logic [7:0] DAS_LAST = 8'(DAS_FRAMES - 1);
   localparam logic [7:0] ARR_LAST = 8'(ARR_FRAMES - 1);

   logic [NUM_ACTIONS-1:0] match;
   logic                   f1;
   logic                   f2;
   logic                   tick;
   state_t                 state_q [NUM_ACTIONS];
   state_t                 state_d [NUM_ACTIONS];
   logic [7:0]             cnt_q   [NUM_ACTIONS];
   logic [7:0]             cnt_d   [NUM_ACTIONS];
   logic [NUM_ACTIONS-1:0] pulse_d;
   logic [NUM_ACTIONS-1:0] pulse_q;

   // A zero byte is an empty slot and must never match, even against a zero code.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (keycode[8*s +: 8] != 8'h00 && keycode[8*s +: 8] == ACTION_CODES[8*i +: 8])
               match[i] = 1'b1;
         end
      end
   end

   assign tick = f1 & ~f2;

   always_comb begin
      pulse_d = '0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (!enable) begin
            state_d[i] = IDLE;
            cnt_d[i]   = 8'd0;
         end else if (tick) begin
            case (state_q[i])
               IDLE: begin
                  if (match[i]) begin
                     pulse_d[i] = 1'b1;
                     cnt_d[i]   = 8'd0;
                     state_d[i] = REPEAT_MASK[i] ? DELAY : LATCH;
                  end
               end
               DELAY: begin
                  if (!match[i]) begin
                     state_d[i] = IDLE;
                     cnt_d[i]   = 8'd0;
                  end else if (cnt_q[i] == DAS_LAST) begin
                     pulse_d[i] = 1'b1;
                     cnt_d[i]   = 8'd0;
                     state_d[i] = REPEAT;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 8'd1;
                  end
               end
               REPEAT: begin
                  if (!match[i]) begin
                     state_d[i] = IDLE;
                     cnt_d[i]   = 8'd0;
                  end else if (cnt_q[i] == ARR_LAST) begin
                     pulse_d[i] = 1'b1;
                     cnt_d[i]   = 8'd0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 8'd1;
                  end
               end
               LATCH: begin
                  if (!match[i]) state_d[i] = IDLE;
               end
               default: begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = 8'd0;
               end
            endcase
         end
      end
   end

   // f1/f2 reset high so a frame_sync already high at release is not seen as a rise.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         f1          <= 1'b1;
         f2          <= 1'b1;
         pulse_q     <= '0;
         action_held <= '0;
         for (int i = 0; i < NUM_ACTIONS; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= 8'd0;
         end
      end else begin
         f1          <= frame_sync;
         f2          <= f1;
         pulse_q     <= pulse_d;
         action_held <= match;
         for (int i = 0; i < NUM_ACTIONS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign action_pulse = pulse_q & {NUM_ACTIONS{enable}};

endmodule
